// File: rtl/stage_fetch.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction memory,
// and tags each returning word with its address, handling stalls and redirects.
module stage_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        pc_wr,
  input  logic [15:0] pc_in,
  output logic        o_pc_rd,
  output logic [15:0] o_pc_addr,
  output logic        valid_out,
  output logic [15:0] pc_out,
  output logic [15:0] pc_next_out,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  // Handshake: the word on mem_data is live when valid_out=1; downstream accepts it
  // in any cycle where stall=0, and a held word stays stable while stall=1.
  state_t      state, state_nx;
  logic [15:0] pc, pc_nx;
  logic [15:0] fetch_pc, fetch_pc_nx;
  logic        inflight, inflight_nx;
  logic [15:0] target;

  assign target = {pc_in[15:1], 1'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RUN;
      pc       <= RESET_PC;
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      fetch_pc <= fetch_pc_nx;
      inflight <= inflight_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    fetch_pc_nx = fetch_pc;
    inflight_nx = inflight;
    o_pc_addr   = pc;
    if (pc_wr) begin
      o_pc_addr   = target;
      fetch_pc_nx = target;
      pc_nx       = target + PC_INC;
      inflight_nx = 1'b1;
      state_nx    = ST_BUBBLE;
    end else if (stall) begin
      // Re-read the held word so mem_data stays stable through the stall.
      o_pc_addr = fetch_pc;
      state_nx  = (state == ST_BUBBLE) ? ST_BUBBLE : ST_STALL;
    end else if (state == ST_BUBBLE) begin
      // The target word was issued during the redirect; re-issue it and wait one more cycle.
      o_pc_addr = fetch_pc;
      state_nx  = ST_RUN;
    end else begin
      o_pc_addr   = pc;
      fetch_pc_nx = pc;
      pc_nx       = pc + PC_INC;
      inflight_nx = 1'b1;
      state_nx    = ST_RUN;
    end
  end

  assign o_pc_rd     = reset_n;
  assign valid_out   = inflight && (state != ST_BUBBLE);
  assign pc_out      = fetch_pc;
  assign pc_next_out = fetch_pc + PC_INC;
  assign state_dbg   = state;

endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: directed scenarios plus random stall/redirect traffic,
// compared each cycle against a stream-level reference model.
module tb_stage_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] PC_INC   = 16'd2;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        pc_wr;
  logic [15:0] pc_in;
  logic        o_pc_rd;
  logic [15:0] o_pc_addr;
  logic        valid_out;
  logic [15:0] pc_out;
  logic [15:0] pc_next_out;
  logic [1:0]  state_dbg;

  stage_fetch #(.RESET_PC(RESET_PC), .PC_INC(PC_INC)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .stall(stall),
    .pc_wr(pc_wr),
    .pc_in(pc_in),
    .o_pc_rd(o_pc_rd),
    .o_pc_addr(o_pc_addr),
    .valid_out(valid_out),
    .pc_out(pc_out),
    .pc_next_out(pc_next_out),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the address being presented, whether the stream has started,
  // and whether the current cycle is the squashed slot after a redirect.
  logic [15:0] m_cur;
  bit          m_started;
  bit          m_bubble;

  // Scoreboard: addresses expected to be accepted downstream, in order.
  logic [15:0] exp_q[$];
  bit          sb_on;

  task automatic model_reset();
    m_cur     = RESET_PC;
    m_started = 1'b0;
    m_bubble  = 1'b0;
  endtask

  // driver: one clock cycle with the given inputs
  task automatic step(input bit s, input bit w, input logic [15:0] tgt);
    logic [15:0] e_addr;
    logic [15:0] e_next;
    logic [15:0] e_tgt;
    stall = s;
    pc_wr = w;
    pc_in = tgt;
    e_tgt  = {tgt[15:1], 1'b0};
    e_next = m_cur + PC_INC;
    if (w)                               e_addr = e_tgt;
    else if (s || m_bubble || !m_started) e_addr = m_cur;
    else                                 e_addr = e_next;
    @(negedge clk);
    check("rd", {31'd0, o_pc_rd}, 32'd1);
    check("addr", {16'd0, o_pc_addr}, {16'd0, e_addr});
    check("valid", {31'd0, valid_out}, {31'd0, (m_started && !m_bubble)});
    check("pc_out", {16'd0, pc_out}, {16'd0, m_cur});
    check("pc_next", {16'd0, pc_next_out}, {16'd0, e_next});
    if (sb_on && valid_out && !s && !w) begin
      if (exp_q.size() > 0) check("stream", {16'd0, pc_out}, {16'd0, exp_q.pop_front()});
      else check("stream_extra", exp_q.size(), 32'd1);
    end
    @(posedge clk);
    if (w) begin
      m_cur     = e_tgt;
      m_started = 1'b1;
      m_bubble  = 1'b1;
    end else if (!s) begin
      if (m_bubble)        m_bubble  = 1'b0;
      else if (!m_started) m_started = 1'b1;
      else                 m_cur     = e_next;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic sb_drained(input string tag);
    check(tag, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] rst_next;
    rst_next = RESET_PC + PC_INC;
    reset_n = 1'b0;
    stall   = 1'b0;
    pc_wr   = 1'b0;
    pc_in   = 16'h0000;
    sb_on   = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd", {31'd0, o_pc_rd}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_pc_out", {16'd0, pc_out}, {16'd0, RESET_PC});
    check("rst_pc_next", {16'd0, pc_next_out}, {16'd0, rst_next});
    @(posedge clk);
    #1 reset_n = 1'b1;

    // start-up, then a 3-cycle stall while pc_out=4
    sb_on = 1'b1;
    exp_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008};
    run(3);
    check("stall_entry_pc", {16'd0, pc_out}, 32'h0004);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000);
    run(3);
    sb_drained("sb_stall");

    // redirect to 0x41 (bit 0 dropped) while pc_out=0x10
    exp_q = '{16'h000a, 16'h000c, 16'h000e, 16'h0040, 16'h0042};
    run(3);
    check("redir_from_pc", {16'd0, pc_out}, 32'h0010);
    step(1'b0, 1'b1, 16'h0041);
    run(3);
    sb_drained("sb_redirect");

    // redirect together with stall, stall held into the bubble
    exp_q = '{16'h0040, 16'h0042};
    step(1'b1, 1'b1, 16'h0041);
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    run(3);
    sb_drained("sb_redir_stall");

    // back-to-back redirects: 0x100 must never be accepted
    exp_q = '{16'h0200, 16'h0202};
    step(1'b0, 1'b1, 16'h0100);
    step(1'b0, 1'b1, 16'h0200);
    run(3);
    sb_drained("sb_b2b");

    // wrap at the top of the address space
    exp_q = '{16'hfffc, 16'hfffe, 16'h0000, 16'h0002};
    step(1'b0, 1'b1, 16'hfffc);
    run(5);
    sb_drained("sb_wrap");
    sb_on = 1'b0;

    // asynchronous reset in the middle of a stall
    step(1'b1, 1'b0, 16'h0000);
    stall = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, valid_out}, 32'd0);
    check("async_rst_pc_out", {16'd0, pc_out}, {16'd0, RESET_PC});
    check("async_rst_rd", {31'd0, o_pc_rd}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    stall   = 1'b0;
    run(3);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit          s;
      bit          w;
      logic [15:0] t;
      s = ($urandom_range(3, 0) == 0);
      w = ($urandom_range(7, 0) == 0);
      t = 16'($urandom_range(16'hffff, 0));
      step(s, w, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
